multadd_seq: RTL and testbench

- Per-lane vector sequencer that sits directly upstream and downstream of the multadd datapath.
- Accepts one vector instruction through a valid/ready handshake and steps element-by-element through two vector-register-file read ports.
- Drives multadd operand and control inputs, then writes multadd's registered result back to the VRF: one write per element for add/sub/mul, or a single write for an FMA dot-product reduction.

---
 rtl/multadd_pkg.sv | 29 ++
 rtl/multadd_seq.sv | 143 ++++++++++++++
 tb/tb_multadd_seq.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multadd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multadd_pkg
// Brief   : Shared definitions for the multadd datapath and its sequencer:
//           ALU op encodings, sequencer state encoding, op normalisation.
// Revision: 1.0  initial release
// ============================================================================
package multadd_pkg;

  // ALU op encodings shared with the multadd datapath
  localparam logic [1:0] MA_ADD = 2'b00;
  localparam logic [1:0] MA_SUB = 2'b01;
  localparam logic [1:0] MA_MUL = 2'b10;
  localparam logic [1:0] MA_RSV = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Reserved encoding behaves as add
  function automatic logic [1:0] ma_op_map(input logic [1:0] op);
    return (op == MA_RSV) ? MA_ADD : op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multadd_seq.sv
`default_nettype none
// ============================================================================
// Module  : multadd_seq
// Brief   : Per-lane vector sequencer. Accepts one vector instruction, walks
//           the elements through two VRF read ports into multadd, and writes
//           multadd's registered result back (per element, or one FMA sum).
// Revision: 1.0  initial release
// ============================================================================
module multadd_seq
  import multadd_pkg::*;
#(
  parameter int vdw_p   = 32,
  parameter int els_p   = 8,
  parameter int vregs_p = 8,
  localparam int EAW    = $clog2(els_p),
  localparam int RAW    = $clog2(vregs_p),
  localparam int AW     = RAW + EAW
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             v_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic             fma_i,
  input  logic [RAW-1:0]   vd_i,
  input  logic [RAW-1:0]   vs1_i,
  input  logic [RAW-1:0]   vs2_i,
  input  logic [EAW:0]     len_i,
  output logic [AW-1:0]    r0_addr_o,
  output logic [AW-1:0]    r1_addr_o,
  input  logic [vdw_p-1:0] r0_data_i,
  input  logic [vdw_p-1:0] r1_data_i,
  output logic [vdw_p-1:0] ma_a_o,
  output logic [vdw_p-1:0] ma_b_o,
  output logic [1:0]       ma_op_o,
  output logic             ma_use_fma_o,
  output logic             ma_fma_first_o,
  input  logic [vdw_p-1:0] ma_data_i,
  output logic             w_v_o,
  output logic [AW-1:0]    w_addr_o,
  output logic [vdw_p-1:0] w_data_o,
  output logic             done_o
);

  localparam logic [EAW:0] c_els = (EAW + 1)'(els_p);

  state_e           r_state;
  logic [EAW-1:0]   r_cnt;
  logic [1:0]       r_op;
  logic             r_fma;
  logic [RAW-1:0]   r_vd;
  logic [RAW-1:0]   r_vs1;
  logic [RAW-1:0]   r_vs2;
  logic [EAW:0]     r_len;

  logic [EAW:0]     w_len_clamp;
  logic [EAW:0]     w_len_m1;
  logic             w_last;

  assign w_len_clamp = (len_i > c_els) ? c_els : len_i;
  assign w_len_m1    = r_len - (EAW + 1)'(1);
  assign w_last      = ({1'b0, r_cnt} == w_len_m1);

  // The write data is multadd's registered result, passed straight through
  assign w_data_o = ma_data_i;

  // Instruction latch, element counter and state sequencing
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= MA_ADD;
      r_fma   <= 1'b0;
      r_vd    <= '0;
      r_vs1   <= '0;
      r_vs2   <= '0;
      r_len   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (v_i) begin
            r_op    <= ma_op_map(op_i);
            r_fma   <= fma_i;
            r_vd    <= vd_i;
            r_vs1   <= vs1_i;
            r_vs2   <= vs2_i;
            r_len   <= w_len_clamp;
            r_cnt   <= '0;
            r_state <= (w_len_clamp == '0) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          r_cnt <= r_cnt + EAW'(1);
          if (w_last) r_state <= DRAIN;
        end
        DRAIN:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output decode; write/done are squashed while reset is asserted so an
  // aborted instruction produces nothing further
  always_comb begin
    ready_o        = (r_state == IDLE);
    r0_addr_o      = '0;
    r1_addr_o      = '0;
    ma_a_o         = '0;
    ma_b_o         = '0;
    ma_op_o        = r_op;
    ma_use_fma_o   = 1'b0;
    ma_fma_first_o = 1'b0;
    w_v_o          = 1'b0;
    w_addr_o       = '0;
    done_o         = 1'b0;
    case (r_state)
      ISSUE: begin
        r0_addr_o      = {r_vs1, r_cnt};
        r1_addr_o      = {r_vs2, r_cnt};
        ma_a_o         = r0_data_i;
        ma_b_o         = r1_data_i;
        ma_use_fma_o   = r_fma;
        ma_fma_first_o = r_fma && (r_cnt == '0);
        ma_op_o        = r_fma ? MA_ADD : r_op;
        // Result of the previous element emerges from multadd this cycle
        if (!r_fma && (r_cnt != '0)) begin
          w_v_o    = !reset_i;
          w_addr_o = {r_vd, r_cnt - EAW'(1)};
        end
      end
      DRAIN: begin
        done_o = !reset_i;
        if (r_len != '0) begin
          w_v_o    = !reset_i;
          w_addr_o = r_fma ? {r_vd, {EAW{1'b0}}} : {r_vd, w_len_m1[EAW-1:0]};
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multadd_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_multadd_seq
// Brief   : Self-checking bench for multadd_seq with a VRF model, a multadd
//           model and a vector-level golden register file.
// Revision: 1.0  initial release
// ============================================================================
module tb_multadd_seq;

  localparam int NE = 8;
  localparam int NR = 8;
  localparam int NW = NE * NR;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        v_i = 1'b0;
  logic        ready_o;
  logic [1:0]  op_i = 2'b00;
  logic        fma_i = 1'b0;
  logic [2:0]  vd_i = '0, vs1_i = '0, vs2_i = '0;
  logic [3:0]  len_i = '0;
  logic [5:0]  r0_addr_o, r1_addr_o;
  logic [31:0] r0_data, r1_data;
  logic [31:0] ma_a_o, ma_b_o;
  logic [1:0]  ma_op_o;
  logic        ma_use_fma_o, ma_fma_first_o;
  logic [31:0] ma_data = '0;
  logic        w_v_o;
  logic [5:0]  w_addr_o;
  logic [31:0] w_data_o;
  logic        done_o;

  logic [31:0] vrf  [NW];
  logic [31:0] gold [NW];
  logic        tb_we = 1'b0;
  logic [5:0]  tb_addr = '0;
  logic [31:0] tb_data = '0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  multadd_seq dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .v_i            (v_i),
    .ready_o        (ready_o),
    .op_i           (op_i),
    .fma_i          (fma_i),
    .vd_i           (vd_i),
    .vs1_i          (vs1_i),
    .vs2_i          (vs2_i),
    .len_i          (len_i),
    .r0_addr_o      (r0_addr_o),
    .r1_addr_o      (r1_addr_o),
    .r0_data_i      (r0_data),
    .r1_data_i      (r1_data),
    .ma_a_o         (ma_a_o),
    .ma_b_o         (ma_b_o),
    .ma_op_o        (ma_op_o),
    .ma_use_fma_o   (ma_use_fma_o),
    .ma_fma_first_o (ma_fma_first_o),
    .ma_data_i      (ma_data),
    .w_v_o          (w_v_o),
    .w_addr_o       (w_addr_o),
    .w_data_o       (w_data_o),
    .done_o         (done_o)
  );

  // Combinational-read VRF
  assign r0_data = vrf[r0_addr_o];
  assign r1_data = vrf[r1_addr_o];

  // VRF write port, shared by the DUT and bench preload
  always @(posedge clk) begin
    if (w_v_o) vrf[w_addr_o] <= w_data_o;
    else if (tb_we) vrf[tb_addr] <= tb_data;
  end

  // multadd model: one-cycle registered result, FMA accumulates into itself
  always @(posedge clk) begin
    if (ma_use_fma_o)
      ma_data <= (ma_fma_first_o ? 32'd0 : ma_data) + ma_a_o * ma_b_o;
    else begin
      case (ma_op_o)
        2'b01:   ma_data <= ma_a_o - ma_b_o;
        2'b10:   ma_data <= ma_a_o * ma_b_o;
        default: ma_data <= ma_a_o + ma_b_o;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      2'b01:   return a - b;
      2'b10:   return a * b;
      default: return a + b;
    endcase
  endfunction

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = 6'(a); tb_data = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
    gold[a] = d;
  endtask

  task automatic setreg(input int r, input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < NE; i++) poke(r * NE + i, base + step * i);
  endtask

  task automatic cmp_vrf(input string tag);
    for (int i = 0; i < NW; i++) chk($sformatf("%s vrf[%0d]", tag, i), vrf[i], gold[i]);
  endtask

  task automatic wait_ready();
    int w = 0;
    @(negedge clk);
    while (!ready_o && w < 50) begin @(negedge clk); w++; end
    chk("ready_before_issue", ready_o, 1);
  endtask

  task automatic run_instr(input logic [1:0] op, input logic fma, input int vd,
                           input int vs1, input int vs2, input int len, input string tag);
    logic [31:0] ew [NE];
    logic [31:0] sum;
    logic [1:0]  eop;
    int L, nexp, t, nw, done_t, rlow, ffirst, first_t;
    L    = (len > NE) ? NE : len;
    sum  = '0;
    eop  = fma ? 2'b00 : ((op == 2'b11) ? 2'b00 : op);
    for (int i = 0; i < NE; i++) ew[i] = '0;
    for (int i = 0; i < L; i++) begin
      if (fma) sum += gold[vs1 * NE + i] * gold[vs2 * NE + i];
      else     ew[i] = ref_op(op, gold[vs1 * NE + i], gold[vs2 * NE + i]);
    end
    if (fma) ew[0] = sum;
    nexp = (L == 0) ? 0 : (fma ? 1 : L);

    wait_ready();
    v_i = 1'b1; op_i = op; fma_i = fma;
    vd_i = 3'(vd); vs1_i = 3'(vs1); vs2_i = 3'(vs2); len_i = 4'(len);
    @(posedge clk);
    #1 v_i = 1'b0;

    t = 0; nw = 0; done_t = -1; rlow = 0; ffirst = 0; first_t = -1;
    while (done_t < 0 && t < 40) begin
      @(negedge clk);
      t++;
      if (!ready_o) rlow++;
      if (ma_fma_first_o) begin ffirst++; first_t = t; end
      if (t <= L) begin
        chk($sformatf("%s r0_addr t%0d", tag, t), r0_addr_o, vs1 * NE + t - 1);
        chk($sformatf("%s r1_addr t%0d", tag, t), r1_addr_o, vs2 * NE + t - 1);
        chk($sformatf("%s ma_op t%0d", tag, t), ma_op_o, eop);
        chk($sformatf("%s use_fma t%0d", tag, t), ma_use_fma_o, fma);
      end
      if (w_v_o) begin
        if (nw < NE) begin
          chk($sformatf("%s waddr%0d", tag, nw), w_addr_o, vd * NE + (fma ? 0 : nw));
          chk($sformatf("%s wdata%0d", tag, nw), w_data_o, ew[fma ? 0 : nw]);
          chk($sformatf("%s wtime%0d", tag, nw), t, fma ? L + 1 : nw + 2);
        end
        nw++;
      end
      if (done_o) done_t = t;
    end
    chk({tag, " done_time"}, done_t, L + 1);
    chk({tag, " n_writes"}, nw, nexp);
    chk({tag, " ready_low"}, rlow, L + 1);
    chk({tag, " fma_first_cnt"}, ffirst, (fma && L > 0) ? 1 : 0);
    if (fma && L > 0) chk({tag, " fma_first_time"}, first_t, 1);

    if (fma) begin
      if (L > 0) gold[vd * NE] = sum;
    end else begin
      for (int i = 0; i < L; i++) gold[vd * NE + i] = ew[i];
    end
    @(negedge clk);
    chk({tag, " ready_after"}, ready_o, 1);
    chk({tag, " wv_after"}, w_v_o, 0);
    cmp_vrf(tag);
  endtask

  initial begin
    int nd, nwr;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst ready", ready_o, 1);
    chk("rst w_v", w_v_o, 0);
    chk("rst done", done_o, 0);
    chk("rst use_fma", ma_use_fma_o, 0);
    chk("rst fma_first", ma_fma_first_o, 0);
    chk("rst ma_op", ma_op_o, 0);
    chk("rst ma_a", ma_a_o, 0);
    reset_i = 1'b0;

    for (int i = 0; i < NW; i++) poke(i, $urandom);

    // Elementwise add across a full vector
    setreg(0, 1, 1);
    setreg(1, 10, 10);
    run_instr(2'b00, 1'b0, 2, 0, 1, 8, "add8");
    chk("add8 el0", vrf[16], 11);
    chk("add8 el7", vrf[23], 88);

    // Subtract with short length; upper elements untouched
    setreg(5, 5, 0);
    setreg(6, 7, 0);
    run_instr(2'b01, 1'b0, 7, 5, 6, 3, "sub3");
    chk("sub3 el2", vrf[58], 32'hFFFF_FFFE);

    // Multiply truncation
    setreg(6, 32'h1_0000, 0);
    setreg(7, 32'h1_0000, 0);
    run_instr(2'b10, 1'b0, 0, 6, 7, 2, "mul2");
    chk("mul2 el1", vrf[1], 0);

    // FMA dot product with destination aliasing a source
    setreg(3, 1, 1);
    setreg(4, 1, 1);
    run_instr(2'b10, 1'b1, 3, 3, 4, 4, "fma4");
    chk("fma4 sum", vrf[24], 30);
    chk("fma4 el3", vrf[27], 4);

    // Zero length, clamped length, reserved op, elementwise aliasing
    run_instr(2'b00, 1'b0, 1, 2, 3, 0, "len0");
    run_instr(2'b00, 1'b1, 1, 2, 3, 0, "fmalen0");
    run_instr(2'b00, 1'b0, 6, 0, 1, 15, "len15");
    run_instr(2'b11, 1'b0, 5, 0, 1, 5, "rsv");
    run_instr(2'b01, 1'b0, 4, 4, 3, 8, "alias");

    // Reset in the third ISSUE cycle of a length-8 add
    setreg(0, 3, 2);
    setreg(1, 100, 7);
    poke(4 * NE + 1, 32'd3 + 32'd2 + 32'd107);
    wait_ready();
    v_i = 1'b1; op_i = 2'b00; fma_i = 1'b0; vd_i = 3'd4; vs1_i = 3'd0; vs2_i = 3'd1; len_i = 4'd8;
    @(posedge clk);
    #1 v_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid wv_t2", w_v_o, 1);
    chk("rstmid waddr_t2", w_addr_o, 4 * NE);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    chk("rstmid ready", ready_o, 1);
    chk("rstmid done", done_o, 0);
    chk("rstmid wv", w_v_o, 0);
    reset_i = 1'b0;
    nd = 0; nwr = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_o) nd++;
      if (w_v_o) nwr++;
    end
    chk("rstmid late_done", nd, 0);
    chk("rstmid late_writes", nwr, 0);
    gold[4 * NE] = 32'd3 + 32'd100;
    cmp_vrf("rstmid");
    run_instr(2'b00, 1'b1, 2, 0, 1, 2, "fma_after_rst");

    // Randomised instructions
    for (int k = 0; k < 24; k++) begin
      if (k % 6 == 0) setreg($urandom_range(0, NR - 1), $urandom, $urandom);
      run_instr(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
                $urandom_range(0, NR - 1), $urandom_range(0, 15), $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
